// File: rtl/lsu_rvs_if.sv
// lsu_rvs_if: bundles the dispatch, CDB snoop and lsu issue signals of the
// load/store reservation queue.
//   slave  : the queue itself (takes dispatch/CDB/lsu_rdy, drives dis_rdy/lsu_*)
//   master : the environment around it (dispatch, CDB and lsu)
// Handshakes: a transfer happens on a rising clk edge where valid (dis_req /
// lsu_req) and ready (dis_rdy / lsu_rdy) are both high. Once raised, lsu_req
// holds with a stable payload until accepted (flush/reset excepted). cdb_vld
// is a broadcast and has no ready.
interface lsu_rvs_if #(parameter int TAG_W = 4);
  logic             dis_req;
  logic             dis_rdy;
  logic [3:0]       dis_opc;
  logic [TAG_W-1:0] dis_tag;
  logic [11:0]      dis_offset;
  logic             dis_src1_vld;
  logic [TAG_W-1:0] dis_src1_tag;
  logic [31:0]      dis_src1_data;
  logic             dis_src2_vld;
  logic [TAG_W-1:0] dis_src2_tag;
  logic [31:0]      dis_src2_data;
  logic             cdb_vld;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_wdata;
  logic             lsu_req;
  logic             lsu_rdy;
  logic [3:0]       lsu_opc;
  logic [TAG_W-1:0] lsu_tag;
  logic [31:0]      lsu_src1;
  logic [31:0]      lsu_src2;
  logic [11:0]      lsu_offset;

  modport slave (
    input  dis_req, dis_opc, dis_tag, dis_offset,
    input  dis_src1_vld, dis_src1_tag, dis_src1_data,
    input  dis_src2_vld, dis_src2_tag, dis_src2_data,
    input  cdb_vld, cdb_tag, cdb_wdata, lsu_rdy,
    output dis_rdy, lsu_req, lsu_opc, lsu_tag, lsu_src1, lsu_src2, lsu_offset
  );

  modport master (
    output dis_req, dis_opc, dis_tag, dis_offset,
    output dis_src1_vld, dis_src1_tag, dis_src1_data,
    output dis_src2_vld, dis_src2_tag, dis_src2_data,
    output cdb_vld, cdb_tag, cdb_wdata, lsu_rdy,
    input  dis_rdy, lsu_req, lsu_opc, lsu_tag, lsu_src1, lsu_src2, lsu_offset
  );
endinterface

// File: rtl/lsu_rvs.sv
// lsu_rvs: in-order reservation queue for load/store ops in front of the lsu.
// Captures operand values by snooping the CDB and issues only the head entry,
// so memory ops leave in program order.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset (empties the queue)
//   flush  : synchronous clear of all entries
//   bus    : lsu_rvs_if.slave (dispatch in, CDB snoop, lsu issue out)
module lsu_rvs #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  lsu_rvs_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] head, tail;
  logic [IDX_W-1:0] head_idx, tail_idx;

  logic [DEPTH-1:0] ent_vld;
  logic [3:0]       ent_opc    [DEPTH];
  logic [TAG_W-1:0] ent_tag    [DEPTH];
  logic [11:0]      ent_off    [DEPTH];
  logic             ent_s1_rdy [DEPTH];
  logic [TAG_W-1:0] ent_s1_tag [DEPTH];
  logic [31:0]      ent_s1_data[DEPTH];
  logic             ent_s2_rdy [DEPTH];
  logic [TAG_W-1:0] ent_s2_tag [DEPTH];
  logic [31:0]      ent_s2_data[DEPTH];

  logic full, dis_fire, iss_fire;
  logic dis_s1_hit, dis_s2_hit;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head[PTR_W-1] != tail[PTR_W-1]);

  // No bypass: a full queue refuses dispatch even when the head leaves this cycle.
  assign bus.dis_rdy = !full;
  assign dis_fire    = bus.dis_req && !full;

  assign bus.lsu_req    = ent_vld[head_idx] && ent_s1_rdy[head_idx] && ent_s2_rdy[head_idx];
  assign bus.lsu_opc    = ent_opc[head_idx];
  assign bus.lsu_tag    = ent_tag[head_idx];
  assign bus.lsu_src1   = ent_s1_data[head_idx];
  assign bus.lsu_src2   = ent_s2_data[head_idx];
  assign bus.lsu_offset = ent_off[head_idx];
  assign iss_fire       = bus.lsu_req && bus.lsu_rdy;

  // A source that is being broadcast in the dispatch cycle is captured on the
  // way in; otherwise the wakeup would be missed.
  assign dis_s1_hit = !bus.dis_src1_vld && bus.cdb_vld && (bus.dis_src1_tag == bus.cdb_tag);
  assign dis_s2_hit = !bus.dis_src2_vld && bus.cdb_vld && (bus.dis_src2_tag == bus.cdb_tag);

  // Control state: pointers and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      ent_vld <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      ent_vld <= '0;
    end else begin
      // head_idx == tail_idx with both firing is impossible: issue needs a
      // non-empty queue and dispatch a non-full one.
      if (iss_fire) begin
        ent_vld[head_idx] <= 1'b0;
        head              <= head + 1'b1;
      end
      if (dis_fire) begin
        ent_vld[tail_idx] <= 1'b1;
        tail              <= tail + 1'b1;
      end
    end
  end

  // Payload and operand readiness: not reset, only meaningful under ent_vld.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (dis_fire && (IDX_W'(i) == tail_idx)) begin
        ent_opc[i]     <= bus.dis_opc;
        ent_tag[i]     <= bus.dis_tag;
        ent_off[i]     <= bus.dis_offset;
        ent_s1_tag[i]  <= bus.dis_src1_tag;
        ent_s2_tag[i]  <= bus.dis_src2_tag;
        ent_s1_rdy[i]  <= bus.dis_src1_vld || dis_s1_hit;
        ent_s2_rdy[i]  <= bus.dis_src2_vld || dis_s2_hit;
        ent_s1_data[i] <= bus.dis_src1_vld ? bus.dis_src1_data : bus.cdb_wdata;
        ent_s2_data[i] <= bus.dis_src2_vld ? bus.dis_src2_data : bus.cdb_wdata;
      end else if (bus.cdb_vld && ent_vld[i]) begin
        if (!ent_s1_rdy[i] && (ent_s1_tag[i] == bus.cdb_tag)) begin
          ent_s1_rdy[i]  <= 1'b1;
          ent_s1_data[i] <= bus.cdb_wdata;
        end
        if (!ent_s2_rdy[i] && (ent_s2_tag[i] == bus.cdb_tag)) begin
          ent_s2_rdy[i]  <= 1'b1;
          ent_s2_data[i] <= bus.cdb_wdata;
        end
      end
    end
  end
endmodule
